// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: fetch state encoding and the filler words
// also used by the decoder and control unit.
// No logic; types and constants only.
package instruction_fetch_unit_pkg;

  // Fetch sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,  // mem_addr = pc, memory read in flight
    LATCH  = 2'd1,  // mem_data valid this cycle, captured at the edge
    VALID  = 2'd2,  // word presented to the decoder, waiting for ack
    HALTED = 2'd3   // fetch stopped by HLT, waiting for resume
  } fetch_state_t;

  // Word shown to the decoder out of reset, before anything is fetched.
  localparam logic [15:0] RESET_WORD = 16'hFFFF;
  // Opcode-safe filler shown after a redirect and while halted.
  localparam logic [15:0] NOP_WORD   = 16'hE000;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: load target, increment (modulo 2^ADDR_WIDTH) or hold.
// Latency: 1 cycle from i_load/i_inc to o_pc; load has priority over increment.
// Ports: i_clock, i_reset (async, active-high), i_load, i_inc, i_target -> o_pc.
module program_counter #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [ADDR_WIDTH-1:0] i_target,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc <= RESET_VECTOR;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      // All-ones wraps to zero silently.
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory, presents one word to the decoder.
// Latency: 2 cycles from FETCH (or redirect) to instr_valid; 3 cycles/instruction with immediate ack.
// Backpressure: presented word held until instr_ack; branch_taken overrides everything but reset.
// Ports: clock, reset; mem_addr/mem_data (1-cycle read); instr_ack, halt_req, resume,
//        branch_taken/branch_target from control; Instruction, instr_valid, instr_pc, halted out.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    INSTRUCTION_WIDTH = 16,
  parameter int                    ADDR_WIDTH        = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  input  logic                         instr_ack,
  input  logic                         branch_taken,
  input  logic [ADDR_WIDTH-1:0]        branch_target,
  input  logic                         halt_req,
  input  logic                         resume,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instr_valid,
  output logic [ADDR_WIDTH-1:0]        instr_pc,
  output logic                         halted
);

  localparam logic [INSTRUCTION_WIDTH-1:0] W_RESET = INSTRUCTION_WIDTH'(RESET_WORD);
  localparam logic [INSTRUCTION_WIDTH-1:0] W_NOP   = INSTRUCTION_WIDTH'(NOP_WORD);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic w_pc_load;
  logic w_pc_inc;
  logic w_capture;    // LATCH -> VALID: take mem_data
  logic w_retire;     // ack without halt: word consumed
  logic w_halt_go;    // ack with halt: enter HALTED
  logic w_resume_go;  // leave HALTED

  logic [ADDR_WIDTH-1:0]        w_pc;
  logic [INSTRUCTION_WIDTH-1:0] r_instr;
  logic                         r_valid;
  logic                         r_halted;
  logic [ADDR_WIDTH-1:0]        r_instr_pc;

  program_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_load   (w_pc_load),
    .i_inc    (w_pc_inc),
    .i_target (branch_target),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_load   = 1'b0;
    w_pc_inc    = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    w_halt_go   = 1'b0;
    w_resume_go = 1'b0;
    if (branch_taken) begin
      // Redirect from any state; returning to FETCH also drops any word that
      // was in flight, since LATCH is where mem_data gets captured.
      w_next    = FETCH;
      w_pc_load = 1'b1;
    end else begin
      unique case (r_state)
        FETCH: w_next = LATCH;
        LATCH: begin
          w_next    = VALID;
          w_capture = 1'b1;
        end
        VALID: begin
          if (instr_ack) begin
            if (halt_req) begin
              w_next    = HALTED;
              w_halt_go = 1'b1;
            end else begin
              w_next   = FETCH;
              w_pc_inc = 1'b1;
              w_retire = 1'b1;
            end
          end
        end
        HALTED: begin
          if (resume) begin
            w_next      = FETCH;
            w_pc_inc    = 1'b1;
            w_resume_go = 1'b1;
          end
        end
        default: w_next = FETCH;
      endcase
    end
  end

  // Decoder-facing registers. Instruction only changes on capture or when it
  // is replaced by the NOP filler, so it is stable throughout VALID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr    <= W_RESET;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_instr_pc <= RESET_VECTOR;
    end else if (branch_taken) begin
      r_instr  <= W_NOP;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_capture) begin
      r_instr    <= mem_data;
      r_instr_pc <= w_pc;
      r_valid    <= 1'b1;
    end else if (w_retire) begin
      r_instr <= W_NOP;
      r_valid <= 1'b0;
    end else if (w_halt_go) begin
      r_instr  <= W_NOP;
      r_valid  <= 1'b0;
      r_halted <= 1'b1;
    end else if (w_resume_go) begin
      r_halted <= 1'b0;
    end
  end

  // The PC is itself a register, so the memory address is registered too.
  assign mem_addr    = w_pc;
  assign Instruction = r_instr;
  assign instr_valid = r_valid;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// control traffic, compared every cycle against a transaction-level model.
// Memory is a synchronous 1-cycle-latency ROM whose contents come from memf().
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = 16'h0;
  logic        instr_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] Instruction;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .instr_ack     (instr_ack),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .Instruction   (Instruction),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2005;
    if (a == 16'h0001) return 16'h0000;
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  always @(posedge clock) mem_data <= memf(mem_addr);

  // Reference model: what the decoder should see, in terms of "next word
  // arrives after m_wait more edges" rather than named sequencer states.
  logic [15:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halted, m_known;
  int          m_wait;

  task automatic model_reset();
    m_pc = 16'h0; m_instr = 16'hFFFF; m_ipc = 16'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_known = 1'b1; m_wait = 2;
  endtask

  task automatic model_step(input logic ack, input logic hreq, input logic br,
                            input logic [15:0] tgt, input logic res);
    if (br) begin
      m_pc = tgt; m_wait = 2; m_valid = 1'b0; m_halted = 1'b0;
      m_instr = 16'hE000; m_known = 1'b1;
    end else if (m_valid && ack) begin
      m_valid = 1'b0;
      if (hreq) begin
        m_halted = 1'b1; m_instr = 16'hE000; m_known = 1'b1; m_wait = -1;
      end else begin
        m_pc = m_pc + 16'd1; m_wait = 2; m_known = 1'b0;
      end
    end else if (m_halted && res) begin
      m_halted = 1'b0; m_pc = m_pc + 16'd1; m_wait = 2;
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_instr = memf(m_pc); m_ipc = m_pc; m_known = 1'b1;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("mem_addr", mem_addr, m_pc);
    check_eq("instr_valid", 16'(instr_valid), 16'(m_valid));
    check_eq("halted", 16'(halted), 16'(m_halted));
    if (m_known) check_eq("instruction", Instruction, m_instr);
    if (m_valid) check_eq("instr_pc", instr_pc, m_ipc);
  endtask

  // One clock: drive at the falling edge, model at the rising edge,
  // compare 1 time unit later, return at the next falling edge.
  task automatic cycle(input logic ack, input logic hreq, input logic br,
                       input logic [15:0] tgt, input logic res);
    instr_ack = ack; halt_req = hreq; branch_taken = br;
    branch_target = tgt; resume = res;
    @(posedge clock);
    model_step(ack, hreq, br, tgt, res);
    #1 compare_all();
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_instr"}, Instruction, 16'hFFFF);
    check_eq({tag, "_valid"}, 16'(instr_valid), 16'h0);
    check_eq({tag, "_pc"}, instr_pc, 16'h0);
    check_eq({tag, "_halted"}, 16'(halted), 16'h0);
    check_eq({tag, "_addr"}, mem_addr, 16'h0);
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Immediate ack: words at cycles 2 and 5.
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      if (i == 2) begin
        check_eq("first_valid", 16'(instr_valid), 16'h1);
        check_eq("first_word", Instruction, 16'h2005);
        check_eq("first_pc", instr_pc, 16'h0000);
      end
      if (i == 5) begin
        check_eq("second_word", Instruction, 16'h0000);
        check_eq("second_pc", instr_pc, 16'h0001);
      end
    end

    // Stall in VALID for 10 cycles.
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("stall_valid", 16'(instr_valid), 16'h1);
    check_eq("stall_pc", instr_pc, 16'h0001);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("after_stall_addr", mem_addr, 16'h0002);

    // Redirect while in LATCH.
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0040, 1'b0);
    check_eq("redir_nop", Instruction, 16'hE000);
    check_eq("redir_addr", mem_addr, 16'h0040);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("redir_pc", instr_pc, 16'h0040);
    check_eq("redir_word", Instruction, memf(16'h0040));

    // Halt at pc=7, resume 5 cycles later.
    cycle(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check_eq("halt_flag", 16'(halted), 16'h1);
    check_eq("halt_valid", 16'(instr_valid), 16'h0);
    check_eq("halt_nop", Instruction, 16'hE000);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("halt_hold_addr", mem_addr, 16'h0007);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check_eq("resume_addr", mem_addr, 16'h0008);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("resume_pc", instr_pc, 16'h0008);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0123, 1'b1);
    check_eq("br_resume_addr", mem_addr, 16'h0123);
    check_eq("br_resume_halted", 16'(halted), 16'h0);

    // Wrap-around at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("wrap_pc", instr_pc, 16'hFFFF);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("wrap_addr", mem_addr, 16'h0000);

    // Asynchronous reset in the middle of a VALID cycle.
    cycle(1'b0, 1'b0, 1'b1, 16'h0300, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("pre_reset_valid", 16'(instr_valid), 16'h1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("post_reset_valid", 16'(instr_valid), 16'h1);
    check_eq("post_reset_word", Instruction, 16'h2005);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        a, h, b, r;
      logic [15:0] t;
      a = ($urandom_range(0, 1) == 1);
      h = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                      : 16'($urandom);
      cycle(a, h, b, t, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
